// File: rtl/instr_prefetch_decoder.sv
// Halfword prefetch FIFO with group classification, group-5 pair assembly and a registered output stage.
// Define INSTR_DEC_ILLEGAL_TRAP_EN to add the sticky `illegal` trap that halts on an unknown-group head.
module instr_prefetch_decoder #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_word,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_group,
    output logic [15:0]            out_instr_hi,
    output logic [15:0]            out_instr_lo,
    output logic                   out_is_long,
    output logic [PC_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    ,
    output logic                   illegal
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]     mem_word [DEPTH];
    logic [PC_W-1:0] mem_pc   [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_ptr_lo;
    logic [CW-1:0]   count;

    logic [15:0]     head_word;
    logic [15:0]     low_word;
    logic [PC_W-1:0] head_pc;
    logic [2:0]      head_group;
    logic            head_long;
    logic            has_one;
    logic            has_two;
    logic            head_complete;
    logic            can_take;
    logic            push;
    logic            load;
    logic [CW-1:0]   pop_cnt;

    function automatic logic [2:0] classify(input logic [15:0] w);
        logic [2:0] g;
        g = 3'd0;
        casez (w[15:10])
            6'b0?????: g = 3'd1;
            6'b10????: g = 3'd2;
            6'b1100??: g = 3'd3;
            6'b1101??: g = 3'd4;
            6'b111000: g = 3'd5;
            default:   g = 3'd0;
        endcase
        return g;
    endfunction

    assign in_ready   = rst_n && !flush && (count < FULL);
    assign push       = in_valid && in_ready;
    assign fifo_count = count;

    assign rd_ptr_lo  = rd_ptr + PW'(1);
    assign head_word  = mem_word[rd_ptr];
    assign head_pc    = mem_pc[rd_ptr];
    // The entry after a group-5 head is its low halfword and is never classified.
    assign low_word   = mem_word[rd_ptr_lo];
    assign head_group = classify(head_word);
    assign head_long  = (head_group == 3'd5);

    assign has_one       = (count != '0);
    assign has_two       = (count >= CW'(2));
    assign head_complete = has_one && (!head_long || has_two);
    assign can_take      = !out_valid || out_ready;

`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    logic head_bad;
    logic set_illegal;

    assign head_bad    = (head_group == 3'd0);
    assign set_illegal = !flush && has_one && head_bad;
    assign load        = !flush && head_complete && can_take && !illegal && !head_bad;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            illegal <= 1'b0;
        end else if (set_illegal) begin
            illegal <= 1'b1;
        end
    end
`else
    assign load = !flush && head_complete && can_take;
`endif

    always_comb begin
        pop_cnt = '0;
        if (load) begin
            pop_cnt = head_long ? CW'(2) : CW'(1);
        end
    end

    // Storage is not reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= in_word;
            mem_pc[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr + pop_cnt[PW-1:0];
            count  <= count + CW'(push) - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_group    <= 3'd0;
            out_instr_hi <= 16'h0000;
            out_instr_lo <= 16'h0000;
            out_is_long  <= 1'b0;
            out_pc       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_group    <= head_group;
            out_instr_hi <= head_word;
            out_instr_lo <= head_long ? low_word : 16'h0000;
            out_is_long  <= head_long;
            out_pc       <= head_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_decoder.sv
// Directed bench for instr_prefetch_decoder: expected instructions are queued as stimulus is
// issued and compared against every output handshake; direct checks cover latency, fill and flush.
module tb_instr_prefetch_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic [15:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_group;
    logic [15:0] out_instr_hi;
    logic [15:0] out_instr_lo;
    logic        out_is_long;
    logic [15:0] out_pc;
    logic [2:0]  fifo_count;
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [2:0]  grp;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        lng;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_got;
    exp_t mon_want;

    always #5 clk = ~clk;

    instr_prefetch_decoder #(.DEPTH(4), .PC_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_group    (out_group),
        .out_instr_hi (out_instr_hi),
        .out_instr_lo (out_instr_lo),
        .out_is_long  (out_is_long),
        .out_pc       (out_pc),
        .fifo_count   (fifo_count)
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
        ,
        .illegal      (illegal)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_instr(input logic [2:0] g, input logic [15:0] hi, input logic [15:0] lo,
                                input logic [15:0] pc);
        sb.push_back({g, hi, lo, (g == 3'd5), pc});
    endtask

    // Holds the word until an edge accepts it; returns #1 after that edge.
    task automatic send(input logic [15:0] w, input logic [15:0] pc);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_word  = w;
        in_pc    = pc;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        in_valid = 1'b0;
        check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        check("drain_done", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
    endtask

    // Output handshakes are compared at the falling edge, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_got = {out_group, out_instr_hi, out_instr_lo, out_is_long, out_pc};
            tests++;
            assert (sb.size() != 0) else begin
                failed++;
                $error("FAIL sb_unexpected: observed %h expected no output", mon_got);
            end
            if (sb.size() != 0) begin
                mon_want = sb.pop_front();
                tests++;
                assert (mon_got === mon_want) else begin
                    failed++;
                    $error("FAIL sb_instr: observed %h expected %h", mon_got, mon_want);
                end
            end
        end
        if (flush || !rst_n) begin
            sb.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = 16'h0000;
        in_pc     = 16'h0000;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick(2);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_group", {29'd0, out_group}, 32'd0);
        check("rst_hi", {16'd0, out_instr_hi}, 32'd0);
        check("rst_lo", {16'd0, out_instr_lo}, 32'd0);
        check("rst_long", {31'd0, out_is_long}, 32'd0);
        check("rst_pc", {16'd0, out_pc}, 32'd0);
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
        check("rst_illegal", {31'd0, illegal}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Stream: two single-word instructions back to back
        out_ready = 1'b1;
        expect_instr(3'd1, 16'h1234, 16'h0000, 16'h0100);
        expect_instr(3'd2, 16'h8A5B, 16'h0000, 16'h0101);
        in_valid = 1'b1;
        in_word  = 16'h1234;
        in_pc    = 16'h0100;
        tick();
        check("stream_lat1_valid", {31'd0, out_valid}, 32'd0);
        check("stream_lat1_count", {29'd0, fifo_count}, 32'd1);
        in_word = 16'h8A5B;
        in_pc   = 16'h0101;
        tick();
        check("stream_lat2_valid", {31'd0, out_valid}, 32'd1);
        check("stream_first_hi", {16'd0, out_instr_hi}, 32'h1234);
        check("stream_first_pc", {16'd0, out_pc}, 32'h0100);
        in_valid = 1'b0;
        tick();
        check("stream_second_valid", {31'd0, out_valid}, 32'd1);
        check("stream_second_hi", {16'd0, out_instr_hi}, 32'h8A5B);
        check("stream_second_grp", {29'd0, out_group}, 32'd2);
        tick();
        check("stream_idle_valid", {31'd0, out_valid}, 32'd0);

        // Long assembly with a gap before the low halfword
        send(16'hE123, 16'h0200);
        check("long_wait_count", {29'd0, fifo_count}, 32'd1);
        repeat (3) begin
            tick();
            check("long_wait_valid", {31'd0, out_valid}, 32'd0);
            check("long_wait_ready", {31'd0, in_ready}, 32'd1);
        end
        expect_instr(3'd5, 16'hE123, 16'hABCD, 16'h0200);
        send(16'hABCD, 16'h0201);
        check("long_lat1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("long_lat2_valid", {31'd0, out_valid}, 32'd1);
        check("long_is_long", {31'd0, out_is_long}, 32'd1);
        check("long_lo", {16'd0, out_instr_lo}, 32'hABCD);
        drain();

        // Backpressure: one presented, four buffered, sixth stalls
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            expect_instr(3'd1, 16'h1000 + 16'(i), 16'h0000, 16'h0300 + 16'(i));
        end
        for (int i = 1; i <= 5; i++) begin
            send(16'h1000 + 16'(i), 16'h0300 + 16'(i));
        end
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        in_word  = 16'h1006;
        in_pc    = 16'h0306;
        tick(2);
        check("full_stall_ready", {31'd0, in_ready}, 32'd0);
        check("full_hold_hi", {16'd0, out_instr_hi}, 32'h1001);
        check("full_hold_pc", {16'd0, out_pc}, 32'h0301);
        out_ready = 1'b1;
        send(16'h1006, 16'h0306);
        drain();

        // Flush with three buffered and one presented
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(16'h2000 + 16'(i), 16'h0400 + 16'(i));
        end
        check("flush_pre_count", {29'd0, fifo_count}, 32'd3);
        check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_word  = 16'h7777;
        in_pc    = 16'h0777;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", {29'd0, fifo_count}, 32'd0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        tick(4);
        check("flush_word_dropped", {31'd0, out_valid}, 32'd0);
        expect_instr(3'd1, 16'h0042, 16'h0000, 16'h0500);
        send(16'h0042, 16'h0500);
        drain();

        // Classification boundaries
        expect_instr(3'd3, 16'hC00F, 16'h0000, 16'h0501);
        expect_instr(3'd4, 16'hD0F0, 16'h0000, 16'h0502);
        expect_instr(3'd2, 16'hBFFF, 16'h0000, 16'h0503);
        expect_instr(3'd1, 16'h7FFF, 16'h0000, 16'h0504);
        send(16'hC00F, 16'h0501);
        send(16'hD0F0, 16'h0502);
        send(16'hBFFF, 16'h0503);
        send(16'h7FFF, 16'h0504);
        drain();

`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
        // Unknown head traps and halts until flush
        send(16'hF000, 16'h0600);
        send(16'h1111, 16'h0601);
        tick(3);
        check("trap_illegal", {31'd0, illegal}, 32'd1);
        check("trap_valid", {31'd0, out_valid}, 32'd0);
        check("trap_count", {29'd0, fifo_count}, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("trap_cleared", {31'd0, illegal}, 32'd0);
        check("trap_flush_count", {29'd0, fifo_count}, 32'd0);
        expect_instr(3'd1, 16'h1212, 16'h0000, 16'h0602);
        send(16'h1212, 16'h0602);
        drain();
`else
        // Unknown halfwords pass through as group 0
        expect_instr(3'd0, 16'hF000, 16'h0000, 16'h0600);
        expect_instr(3'd0, 16'hE400, 16'h0000, 16'h0601);
        send(16'hF000, 16'h0600);
        send(16'hE400, 16'h0601);
        drain();
`endif

        // Reset while a group-5 head waits for its low halfword
        send(16'hE000, 16'h0700);
        tick();
        check("rmid_pre_count", {29'd0, fifo_count}, 32'd1);
        check("rmid_pre_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rmid_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("rmid_count", {29'd0, fifo_count}, 32'd0);
        check("rmid_valid", {31'd0, out_valid}, 32'd0);
        check("rmid_group", {29'd0, out_group}, 32'd0);
        check("rmid_hi", {16'd0, out_instr_hi}, 32'd0);
        check("rmid_lo", {16'd0, out_instr_lo}, 32'd0);
        check("rmid_long", {31'd0, out_is_long}, 32'd0);
        check("rmid_pc", {16'd0, out_pc}, 32'd0);
        rst_n = 1'b1;
        tick();
        expect_instr(3'd1, 16'h2222, 16'h0000, 16'h0800);
        send(16'h2222, 16'h0800);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_decoder.md
# instr_prefetch_decoder

Buffers the fetched 16-bit instruction halfword stream in a parametrised FIFO, reassembles two-halfword group 5 instructions, classifies every instruction by group, and presents one complete registered instruction per handshake to the execute stage. It sits between instruction fetch and the per-group field decoders. Compared with the combinational group classifier, it adds buffering, valid/ready backpressure, multi-word assembly, PC tagging and flush.

## Interface
- `DEPTH`, 4: FIFO capacity in halfwords; power of two, at least 2.
- `PC_W`, 16: width of the PC tag carried with each halfword.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `in_valid` in 1: `in_word`/`in_pc` present.
- `in_ready` out 1: FIFO can accept a halfword.
- `in_word` in 16: fetched halfword.
- `in_pc` in PC_W: address of `in_word`.
- `flush` in 1: discard all buffered and presented instructions.
- `out_valid` out 1: decoded instruction held in the output register.
- `out_ready` in 1: consumer accepts the output.
- `out_group` out 3: 0 = unknown, 1–5 = group number.
- `out_instr_hi` out 16: first halfword.
- `out_instr_lo` out 16: second halfword for group 5, otherwise 0.
- `out_is_long` out 1: high iff `out_group` == 5.
- `out_pc` out PC_W: PC of the first halfword.
- `fifo_count` out $clog2(DEPTH)+1: number of halfwords buffered.
- `illegal` out 1: sticky unknown-group trap. Only present with the macro below.

## Operation
- **Classification** of a halfword `w`, checked in this priority order:
  - `w[15]`=0 → group 1
  - `w[15:14]`=10 → group 2
  - `w[15:12]`=1100 → group 3
  - `w[15:12]`=1101 → group 4
  - `w[15:10]`=111000 → group 5
  - anything else → unknown (0).
- **Push:** occurs when `in_valid && in_ready`. `in_ready` = `rst_n && !flush && count < DEPTH`.
- **Head complete:**
  - For a non-group-5 head: when count ≥ 1.
  - For a group-5 head: when count ≥ 2. The next FIFO entry is the low halfword and is never itself classified.
- **Output load:** occurs when the head is complete and (`!out_valid` or `out_ready`).
  - Pops 1 halfword, or 2 for group 5.
  - Loads hi, lo, group, is_long, and `out_pc` = head PC.
- **Output hold:** while `out_valid && !out_ready`, all `out_*` signals are held stable.
- **Simultaneous push and pop:** allowed in the same cycle. count_next = count + push − pop (pop is 0, 1 or 2). Read and write pointers wrap modulo DEPTH.
- **Flush:** dominates every other event.
  - Next cycle: count=0, pointers=0, `out_valid`=0.
  - The push in the flush cycle is ignored.
  - The output handshake in the flush cycle completes normally from the consumer's side, but no new load occurs.
- **Group 5 waiting:** a group-5 head with count=1 waits indefinitely for its low halfword. `in_ready` remains high, since count < DEPTH.

## Timing
- **Reset** (`rst_n`=0 at a clock edge) forces:
  - count=0, pointers=0
  - `out_valid`=0, `out_group`=0, `out_instr_hi`=0, `out_instr_lo`=0, `out_is_long`=0, `out_pc`=0
  - `illegal`=0
  - `in_ready` is 0 while `rst_n` is low.
- **Latency:** a halfword pushed at edge N produces `out_valid` in the cycle after edge N+1. That is 2 edges for a single-word instruction. For group 5, the latency is 2 edges from the push of the low halfword.
- **Throughput:** one instruction per cycle with `in_valid` and `out_ready` held high, for single-word instructions.
- **Reset mid-operation** behaves like flush plus clearing of `illegal`.

## Configuration
- **`INSTR_DEC_ILLEGAL_TRAP_EN` defined:**
  - An unknown-group head is not loaded into the output.
  - Instead, `illegal` sets the next cycle and popping stops, so the FIFO fills and backpressures.
  - Only `flush` or reset clears `illegal` and resumes operation.
- **Macro undefined:**
  - The `illegal` port is absent.
  - An unknown halfword is emitted as a single-word instruction with `out_group`=0 and `out_instr_lo`=0.

## Test plan
- **Stream and throughput:** push 0x1234 @PC 0x0100, then 0x8A5B @0x0101, with `out_ready`=1.
  - Outputs: group 1 (hi 0x1234, pc 0x0100), then group 2 (hi 0x8A5B, pc 0x0101), on consecutive cycles.
  - First `out_valid` 2 edges after the first push.
- **Long assembly:** push 0xE123, idle 3 cycles, then push 0xABCD.
  - `out_valid` stays 0 until 2 edges after 0xABCD is pushed.
  - Output: group 5, hi 0xE123, lo 0xABCD, `out_is_long`=1.
- **Backpressure/full:** DEPTH=4, `out_ready`=0, push 6 single-word halfwords.
  - First is presented; 4 are buffered; `in_ready`=0 with `fifo_count`=4.
  - Release `out_ready` → all 5 are drained in order, and the sixth is accepted once space frees.
- **Flush:** with 3 buffered halfwords and `out_valid`=1, assert `flush` with `in_valid`=1.
  - Next cycle: `fifo_count`=0, `out_valid`=0.
  - The flush-cycle word does not appear at the output.
- **Unknown, macro undefined:** push 0xF000 → `out_group`=0.
- **Unknown, macro defined:** push 0xF000, then 0x1111 → `illegal`=1, 0x1111 is never output; a flush clears `illegal`.
- **Reset mid-stream:** drop `rst_n` for 1 edge while 0xE000 is buffered awaiting its low halfword → all outputs 0, `fifo_count`=0.
